// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, EX redirect flush and multi-cycle EX hold.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_redirect,
  input  logic             ex_mc_start,
  input  logic             mc_done,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   load_use_c;

  // Load in EX writes a register the ID instruction is about to read.
  assign load_use_c = ex_mem_read && (ex_rd_addr != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                       (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (ex_mc_start && mc_done) begin
          state_d = RUN;
        end else if (ex_mc_start) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          state_d       = MC_WAIT;
        end else if (load_use_c) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      MC_WAIT: begin
        // Redirect, new starts and load-use are frozen behind the busy unit.
        if (mc_done) begin
          state_d = RUN;
        end else begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  // Saturating event counters.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (!pc_write && (stall_cycles_q != CNT_MAX))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (if_id_flush && (flush_events_q != CNT_MAX))
      flush_events_d = flush_events_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus multi-cycle and reset sequences.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  typedef struct {
    logic       redir;
    logic       start;
    logic       done;
    logic       mrd;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [5:0] exp;   // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble}
    string      name;
  } vec_t;

  localparam logic [5:0] DEF  = 6'b110100;
  localparam logic [5:0] LU   = 6'b000110;
  localparam logic [5:0] RDR  = 6'b111110;
  localparam logic [5:0] HOLD = 6'b000001;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, ex_mc_start, mc_done;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int n_pass  = 0;
  int n_total = 0;
  logic [5:0] exp_q[$];
  logic [CNT_W-1:0] exp_stall, exp_flush;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_redirect(ex_redirect), .ex_mc_start(ex_mc_start), .mc_done(mc_done),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  function automatic vec_t mk(input logic redir, input logic start, input logic done,
                              input logic mrd, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic u1, input logic u2,
                              input logic [5:0] exp, input string name);
    vec_t v;
    v.redir = redir; v.start = start; v.done = done; v.mrd = mrd; v.rd = rd;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
  endtask

  task automatic drive(input vec_t v);
    ex_redirect = v.redir; ex_mc_start = v.start; mc_done = v.done;
    ex_mem_read = v.mrd; ex_rd_addr = v.rd; id_rs1_addr = v.rs1; id_rs2_addr = v.rs2;
    id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    exp_q.push_back(v.exp);
  endtask

  task automatic compare(input string name);
    logic [5:0] want;
    want = exp_q.pop_front();
    check({name, " ctl"},
          8'({pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble}),
          8'(want));
    check({name, " stall_cnt"}, 8'(stall_cycles), 8'(exp_stall));
    check({name, " flush_cnt"}, 8'(flush_events), 8'(exp_flush));
`ifdef HAZARD_PERF_CNT_EN
    // Model counters advance on the next edge from the expected outputs.
    if (!want[5] && exp_stall != '1) exp_stall = exp_stall + CNT_W'(1);
    if (want[3] && exp_flush != '1) exp_flush = exp_flush + CNT_W'(1);
`endif
  endtask

  task automatic step(input vec_t v);
    @(posedge clk); #1;
    drive(v);
    #3;
    compare(v.name);
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_stall = '0;
    exp_flush = '0;
    idle = mk(0,0,0,0,5'd0,5'd0,5'd0,0,0,DEF,"idle");

    // Reset: outputs follow RUN rules, counters clear.
    rst_n = 1'b0;
    drive(mk(0,0,0,1,5'd7,5'd7,5'd0,1,0,LU,"reset_lu"));
    #3;
    compare("reset_lu");
    #20;
    drive(idle);
    #1;
    compare("reset_idle");
    @(negedge clk);
    rst_n = 1'b1;

    tbl.push_back(mk(0,0,0,0,5'd0,5'd0,5'd0,0,0,DEF,"t_idle"));
    tbl.push_back(mk(0,0,0,1,5'd5,5'd1,5'd5,1,1,LU ,"t_lu_rs2"));
    tbl.push_back(mk(0,0,0,0,5'd5,5'd1,5'd5,1,1,DEF,"t_lu_clear"));
    tbl.push_back(mk(0,0,0,1,5'd0,5'd0,5'd0,1,1,DEF,"t_rd_zero"));
    tbl.push_back(mk(0,0,0,1,5'd9,5'd9,5'd2,1,0,LU ,"t_lu_rs1"));
    tbl.push_back(mk(0,0,0,1,5'd9,5'd9,5'd9,0,0,DEF,"t_unused_src"));
    tbl.push_back(mk(1,0,0,1,5'd5,5'd5,5'd5,1,1,RDR,"t_redir_lu"));
    tbl.push_back(mk(0,1,1,0,5'd0,5'd0,5'd0,0,0,DEF,"t_fast_mc"));
    tbl.push_back(mk(0,0,1,0,5'd0,5'd0,5'd0,0,0,DEF,"t_done_alone"));
    tbl.push_back(mk(0,1,1,1,5'd3,5'd3,5'd0,1,0,DEF,"t_fast_over_lu"));
    tbl.push_back(mk(1,1,0,0,5'd0,5'd0,5'd0,0,0,RDR,"t_redir_mc"));
    tbl.push_back(mk(0,0,0,0,5'd0,5'd0,5'd0,0,0,DEF,"t_still_run"));
    foreach (tbl[i]) step(tbl[i]);

    // Multi-cycle op: start at 0, done at 4, redirect and load-use ignored while waiting.
    step(mk(0,1,0,0,5'd0,5'd0,5'd0,0,0,HOLD,"mc_c0"));
    step(mk(0,0,0,0,5'd0,5'd0,5'd0,0,0,HOLD,"mc_c1"));
    step(mk(1,0,0,0,5'd0,5'd0,5'd0,0,0,HOLD,"mc_c2_redir"));
    step(mk(0,1,0,1,5'd4,5'd4,5'd0,1,0,HOLD,"mc_c3_lu"));
    step(mk(0,0,1,0,5'd0,5'd0,5'd0,0,0,DEF ,"mc_c4_done"));
    step(mk(0,0,0,0,5'd0,5'd0,5'd0,0,0,DEF ,"mc_c5"));

    // Reset mid-wait aborts MC_WAIT; a late mc_done is ignored.
    step(mk(0,1,0,0,5'd0,5'd0,5'd0,0,0,HOLD,"rw_c0"));
    step(mk(0,0,0,0,5'd0,5'd0,5'd0,0,0,HOLD,"rw_c1"));
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(idle);
    exp_stall = '0;
    exp_flush = '0;
    #1;
    compare("rw_c2_reset");
    #1;
    rst_n = 1'b1;
    step(mk(0,0,1,0,5'd0,5'd0,5'd0,0,0,DEF,"rw_late_done"));
    step(mk(0,0,0,0,5'd0,5'd0,5'd0,0,0,DEF,"rw_after"));

    // Saturation: 20 consecutive load-use stalls.
    for (int i = 0; i < 20; i++)
      step(mk(0,0,0,1,5'd6,5'd6,5'd0,1,0,LU,"sat_lu"));
    step(mk(1,0,0,0,5'd0,5'd0,5'd0,0,0,RDR,"sat_redir"));
    step(idle);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that drives the stall, flush and bubble inputs of the IF/ID, ID/EX and EX/MEM pipeline registers. It sits beside the ID/EX register and consumes that register's outputs: the load destination and the EX-resolved redirect and multi-cycle handshake. Its own outputs feed the `flush` and write-enable inputs of the pipeline registers. Load-use stalls and branch/jump flushes are resolved combinationally in the same cycle. Multi-cycle EX operations (mul/div) are tracked by a two-state FSM.

## Interface
- `CNT_W`, default 32: width of the performance counters.

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `id_rs1_addr`  in  5  rs1 of the instruction in ID
- `id_rs2_addr`  in  5  rs2 of the instruction in ID
- `id_uses_rs1`  in  1  ID instruction reads rs1
- `id_uses_rs2`  in  1  ID instruction reads rs2
- `ex_mem_read`  in  1  instruction in EX is a load (ID/EX mem_read output)
- `ex_rd_addr`  in  5  rd of the EX instruction
- `ex_redirect`  in  1  branch taken or jump resolved in EX this cycle
- `ex_mc_start`  in  1  EX instruction is multi-cycle; its unit starts this cycle
- `mc_done`  in  1  multi-cycle unit result is valid this cycle
- `pc_write`  out  1  PC update enable
- `if_id_write`  out  1  IF/ID load enable
- `if_id_flush`  out  1  IF/ID clear to NOP
- `id_ex_write`  out  1  ID/EX load enable
- `id_ex_flush`  out  1  ID/EX flush; bubble into EX
- `ex_mem_bubble`  out  1  EX/MEM loads a NOP instead of EX results
- `stall_cycles`  out  CNT_W  count of cycles with `pc_write`=0
- `flush_events`  out  CNT_W  count of redirect cycles

## Operation
- FSM states: RUN and MC_WAIT. The state register is the only sequential element apart from the counters.
- Default outputs: all write enables 1, all flush and bubble outputs 0.
- RUN priority, highest first:
  1. Redirect: `ex_redirect`=1 → `if_id_flush`=1, `id_ex_flush`=1, `pc_write`=1. `ex_mc_start` and load-use are ignored. State stays RUN.
  2. Multi-cycle start, fast path: `ex_mc_start`=1 and `mc_done`=1 in the same cycle → single-cycle op. Default outputs; stay RUN.
  3. Multi-cycle start: `ex_mc_start`=1 and `mc_done`=0 → `pc_write`=0, `if_id_write`=0, `id_ex_write`=0, `ex_mem_bubble`=1. Next state is MC_WAIT.
  4. Load-use: condition is `ex_mem_read` and `ex_rd_addr`≠0 and ((`id_uses_rs1` and `id_rs1_addr`==`ex_rd_addr`) or (`id_uses_rs2` and `id_rs2_addr`==`ex_rd_addr`)). Response: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1. State stays RUN.
- MC_WAIT:
  - `mc_done`=0 → same hold outputs as RUN item 3.
  - `mc_done`=1 → default outputs, so the result enters EX/MEM. Next state is RUN.
  - `ex_redirect`, `ex_mc_start` and load-use inputs are ignored.
- `mc_done` in RUN without `ex_mc_start` is ignored.
- Reset: state = RUN and counters = 0. Outputs follow the RUN combinational rules from current inputs.
- Reset asserted in MC_WAIT aborts the wait immediately (asynchronous). Any `mc_done` arriving afterwards is ignored.

## Timing
- All control outputs are combinational from the state and the current inputs: zero-cycle latency into the same-cycle pipeline-register enables.
- Load-use stall lasts exactly 1 cycle. In the next cycle ID/EX holds a bubble (`ex_mem_read`=0), so the condition clears.
- Multi-cycle op: with `ex_mc_start` at cycle 0 and `mc_done` at cycle k≥1, the pipeline is held during cycles 0..k-1. Cycle k releases it, giving k stall cycles.
- Redirect costs 2 bubbles, IF/ID plus ID/EX, and no stall cycles.
- Counters update on the rising `clk` edge following the qualifying cycle and saturate at 2^CNT_W−1.

## Configuration
- Macro `HAZARD_PERF_CNT_EN`.
- Defined: `stall_cycles` increments on every cycle with `pc_write`=0. `flush_events` increments on every cycle where a redirect is honoured (`if_id_flush`=1).
- Undefined: no counter flops are built. Both ports are still present and are driven constant 0.
- Control behaviour is identical either way.

## Test plan
- Load-use stall: `ex_mem_read`=1, `ex_rd_addr`=5, `id_rs2_addr`=5, `id_uses_rs2`=1 → one cycle of `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1. The next cycle, with `ex_mem_read`=0, returns to default outputs. With `ex_rd_addr`=0 → no stall.
- Redirect over load-use: `ex_redirect`=1 together with a matching load-use condition → `if_id_flush`=1, `id_ex_flush`=1, `pc_write`=1. With the macro on, `flush_events` increments 0→1.
- Multi-cycle op: `ex_mc_start` at cycle 0, `mc_done` at cycle 4 → `ex_mem_bubble`=1 and all write enables 0 for cycles 0–3. Default outputs at cycle 4. With the macro on, `stall_cycles`=4. An `ex_redirect` pulse at cycle 2 has no effect.
- Single-cycle fast path: `ex_mc_start`=1 and `mc_done`=1 in the same cycle → no stall, state stays RUN.
- Reset mid-wait: assert `rst_n`=0 at cycle 2 of an MC_WAIT → outputs return to defaults immediately and counters read 0. After release, a late `mc_done` is ignored.
- Saturation (with `CNT_W`=4 and the macro on): hold stall for 20 cycles → `stall_cycles` stops at 15. With the macro off, both counters stay 0 throughout.
